fir_decimate_requantize: RTL and testbench



---
 rtl/fir_decimate_requantize_if.sv | 25 ++
 rtl/fir_decimate_requantize.sv | 102 ++++++++++
 tb/tb_fir_decimate_requantize.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fir_decimate_requantize_if.sv
// Sample stream between the FIR requantizer and its consumer.
// Carries the filter input, the show-ahead FIFO head and its status.
interface fir_decimate_requantize_if #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8,
    parameter int count_width   = 3
);
    logic [word_size_in-1:0]  Data_in;
    logic                     enable;
    logic [word_size_out-1:0] Data_out;
    logic                     Data_valid;
    logic                     Data_ready;
    logic                     overflow;
    logic [count_width-1:0]   fifo_count;

    modport master (
        output Data_in, enable, Data_ready,
        input  Data_out, Data_valid, overflow, fifo_count
    );

    modport slave (
        input  Data_in, enable, Data_ready,
        output Data_out, Data_valid, overflow, fifo_count
    );
endinterface

// File: rtl/fir_decimate_requantize.sv
// Decimates the full-precision FIR output, rounds/saturates each kept sample
// to word_size_out bits and buffers it in a small show-ahead FIFO.
module fir_decimate_requantize #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8,
    parameter int shift         = 8,
    parameter int decim         = 4,
    parameter int fifo_depth    = 4,
    parameter int count_width   = 3
) (
    input logic clock,
    input logic reset,
    fir_decimate_requantize_if.slave bus
);
    localparam int phase_w = (decim > 1) ? $clog2(decim) : 1;
    localparam int ptr_w   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

    localparam logic [word_size_in:0] half    = {{word_size_in{1'b0}}, 1'b1} << (shift - 1);
    localparam logic [word_size_in:0] out_max =
        {{(word_size_in + 1 - word_size_out){1'b0}}, {word_size_out{1'b1}}};

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [word_size_out-1:0] requantize(input logic [word_size_in-1:0] x);
        logic [word_size_in:0] r;
        r = ({1'b0, x} + half) >> shift;
        if (r > out_max)
            return out_max[word_size_out-1:0];
        return r[word_size_out-1:0];
    endfunction

    logic [phase_w-1:0]       phase;
    logic                     keep;
    logic [word_size_out-1:0] sample_p0;
    logic                     pend_p0;

    logic [word_size_out-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]         wr_ptr;
    logic [ptr_w-1:0]         rd_ptr;
    logic [count_width-1:0]   count;
    logic                     full;
    logic                     rd;
    logic                     wr;
    logic                     ovf;

    assign keep = bus.enable && (phase == '0);

    always_ff @(posedge clock) begin
        if (reset)
            phase <= '0;
        else if (bus.enable)
            phase <= (phase == phase_w'(decim - 1)) ? '0 : phase + phase_w'(1);
    end

    // Stage p0: kept sample requantized and held for the FIFO write
    always_ff @(posedge clock) begin
        if (reset)
            pend_p0 <= 1'b0;
        else
            pend_p0 <= keep;
    end

    always_ff @(posedge clock) begin
        if (keep)
            sample_p0 <= requantize(bus.Data_in);
    end

    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign full = (count == count_width'(fifo_depth));
    assign rd   = bus.Data_valid && bus.Data_ready;
    assign wr   = pend_p0 && (!full || rd);

    always_ff @(posedge clock) begin
        if (wr)
            mem[wr_ptr] <= sample_p0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + ptr_w'(1);
            if (rd)
                rd_ptr <= rd_ptr + ptr_w'(1);
            case ({wr, rd})
                2'b10:   count <= count + count_width'(1);
                2'b01:   count <= count - count_width'(1);
                default: count <= count;
            endcase
            if (pend_p0 && full && !rd)
                ovf <= 1'b1;
        end
    end

    assign bus.Data_valid = (count != '0);
    assign bus.Data_out   = bus.Data_valid ? mem[rd_ptr] : '0;
    assign bus.overflow   = ovf;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_fir_decimate_requantize.sv
// Directed bench: two instances (decim=4 and decim=1) sharing clock and reset.
module tb_fir_decimate_requantize;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    fir_decimate_requantize_if #(.word_size_in(18), .word_size_out(8), .count_width(3)) bus4 ();
    fir_decimate_requantize_if #(.word_size_in(18), .word_size_out(8), .count_width(3)) bus1 ();

    fir_decimate_requantize #(.word_size_in(18), .word_size_out(8), .shift(8), .decim(4),
                              .fifo_depth(4), .count_width(3))
        dut4 (.clock(clock), .reset(reset), .bus(bus4));

    fir_decimate_requantize #(.word_size_in(18), .word_size_out(8), .shift(8), .decim(1),
                              .fifo_depth(4), .count_width(3))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Present one value to dut1 (ready=1), check it two edges later, then drained.
    task automatic round1(input logic [17:0] din, input logic [7:0] exp, input string tag);
        bus1.Data_in = din;
        bus1.enable  = 1'b1;
        tick();
        bus1.enable  = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(bus1.Data_valid), 32'd1);
        chk({tag, "_out"}, 32'(bus1.Data_out), 32'(exp));
        tick();
        chk({tag, "_gone"}, 32'(bus1.Data_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_out;
        logic       exp_vld;
        logic [7:0] drain_a [4];
        logic [7:0] drain_b [4];
        drain_a = '{8'd10, 8'd20, 8'd30, 8'd40};
        drain_b = '{8'd2, 8'd3, 8'd4, 8'd5};

        // Reset with live-looking inputs
        bus4.Data_in = 18'h3FFFF; bus4.enable = 1'b1; bus4.Data_ready = 1'b0;
        bus1.Data_in = 18'h3FFFF; bus1.enable = 1'b1; bus1.Data_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_vld", 32'(bus4.Data_valid), 32'd0);
        chk("rst_out", 32'(bus4.Data_out), 32'd0);
        chk("rst_cnt", 32'(bus4.fifo_count), 32'd0);
        chk("rst_ovf", 32'(bus4.overflow), 32'd0);
        chk("rst1_cnt", 32'(bus1.fifo_count), 32'd0);
        reset = 1'b0;
        bus1.enable = 1'b0;

        // Decimation by 4: sample n visible after edge n+1, for one cycle
        bus4.Data_ready = 1'b1;
        for (int n = 0; n < 18; n++) begin
            bus4.Data_in = 18'(n * 256);
            bus4.enable  = (n < 16);
            tick();
            exp_vld = (n % 4 == 1) && (n <= 13);
            exp_out = exp_vld ? 8'(n - 1) : 8'd0;
            chk($sformatf("dec_vld%0d", n), 32'(bus4.Data_valid), 32'(exp_vld));
            chk($sformatf("dec_out%0d", n), 32'(bus4.Data_out), 32'(exp_out));
        end
        bus4.enable = 1'b0;

        // Rounding and saturation
        bus1.Data_ready = 1'b1;
        round1(18'd383,    8'd1,   "rnd383");
        round1(18'd384,    8'd2,   "rnd384");
        round1(18'd65280,  8'd255, "rnd65280");
        round1(18'd65408,  8'd255, "sat65408");
        round1(18'h3FFFF,  8'd255, "satmax");

        // Backpressure and overflow
        do_reset();
        bus1.Data_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus1.Data_in = 18'(i * 10 * 256);
            bus1.enable  = 1'b1;
            tick();
        end
        bus1.enable = 1'b0;
        chk("bp_cnt4", 32'(bus1.fifo_count), 32'd4);
        chk("bp_ovf0", 32'(bus1.overflow), 32'd0);
        tick();
        chk("bp_cnt", 32'(bus1.fifo_count), 32'd4);
        chk("bp_ovf", 32'(bus1.overflow), 32'd1);
        bus1.Data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain%0d", i), 32'(bus1.Data_out), 32'(drain_a[i]));
            tick();
        end
        chk("bp_empty", 32'(bus1.Data_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(bus1.overflow), 32'd1);

        // Full FIFO with simultaneous read and write
        do_reset();
        bus1.Data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus1.Data_in = 18'(i * 256);
            bus1.enable  = 1'b1;
            tick();
        end
        bus1.enable = 1'b0;
        tick();
        chk("rw_full", 32'(bus1.fifo_count), 32'd4);
        bus1.Data_in = 18'(5 * 256);
        bus1.enable  = 1'b1;
        tick();
        bus1.enable     = 1'b0;
        bus1.Data_ready = 1'b1;
        tick();
        bus1.Data_ready = 1'b0;
        chk("rw_cnt", 32'(bus1.fifo_count), 32'd4);
        chk("rw_ovf", 32'(bus1.overflow), 32'd0);
        bus1.Data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rw_drain%0d", i), 32'(bus1.Data_out), 32'(drain_b[i]));
            tick();
        end
        chk("rw_empty", 32'(bus1.Data_valid), 32'd0);

        // Reset mid-operation: 3 entries buffered and one pending in dut4
        do_reset();
        bus4.Data_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bus4.Data_in = 18'((i + 1) * 256);
            bus4.enable  = 1'b1;
            tick();
        end
        bus4.enable = 1'b0;
        chk("mid_cnt_pre", 32'(bus4.fifo_count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_cnt", 32'(bus4.fifo_count), 32'd0);
        chk("mid_vld", 32'(bus4.Data_valid), 32'd0);
        chk("mid_ovf", 32'(bus4.overflow), 32'd0);
        tick();
        chk("mid_no_pend", 32'(bus4.fifo_count), 32'd0);
        bus4.Data_ready = 1'b1;
        bus4.Data_in    = 18'(7 * 256);
        bus4.enable     = 1'b1;
        tick();
        bus4.enable = 1'b0;
        chk("mid_lat1", 32'(bus4.Data_valid), 32'd0);
        tick();
        chk("mid_vld7", 32'(bus4.Data_valid), 32'd1);
        chk("mid_out7", 32'(bus4.Data_out), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
